// File: rtl/psum_rmw_scheduler_pkg.sv
// Shared definitions for the psum scratchpad scheduler: FSM state encoding
// and requester identifiers used by the round-robin arbiter.
package psum_rmw_scheduler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACC_RD,
        ST_ACC_WR,
        ST_DRN_RD,
        ST_DRN_RSP,
        ST_DRN_CLR
    } state_t;

    // Requester identifiers, stored in last_grant
    localparam logic REQ_ACC = 1'b0;
    localparam logic REQ_DRN = 1'b1;

endpackage

// File: rtl/psum_sat_adder.sv
// Signed psum adder: one extra bit of headroom, two's-complement overflow
// detection and optional clamping to the representable range.
module psum_sat_adder #(
    parameter int DATA_WIDTH = 16,
    parameter bit SATURATE   = 1'b1
) (
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    output logic [DATA_WIDTH-1:0] sum,
    output logic                  ovf
);

    localparam int MSB = DATA_WIDTH - 1;

    logic [DATA_WIDTH:0] full;

    // Add with sign extension, flag overflow, clamp if enabled
    always_comb begin
        full = {a[MSB], a} + {b[MSB], b};
        ovf  = (a[MSB] == b[MSB]) && (full[MSB] != a[MSB]);
        sum  = full[MSB:0];
        if (SATURATE && ovf) begin
            sum = a[MSB] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                         : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end

endmodule

// File: rtl/psum_rmw_scheduler.sv
// Owner of the single-port psum scratchpad. Arbitrates accumulate
// (read-modify-write) and drain requests round-robin and serialises every
// memory access so reads and writes never collide.
module psum_rmw_scheduler
    import psum_rmw_scheduler_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter bit SATURATE   = 1'b1,
    parameter bit CLR_ON_DRN = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  acc_req,
    input  logic                  acc_first,
    input  logic [ADDR_WIDTH-1:0] acc_addr,
    input  logic [DATA_WIDTH-1:0] acc_data,
    output logic                  acc_ack,
    input  logic                  drn_req,
    input  logic [ADDR_WIDTH-1:0] drn_addr,
    output logic                  drn_ack,
    output logic                  drn_valid,
    output logic [DATA_WIDTH-1:0] drn_rdata,
    output logic                  mem_ren,
    output logic                  mem_wen,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  busy,
    output logic                  ovf,
    input  logic                  clr_ovf
);

    state_t                  state;
    logic                    last_grant;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   data_q;
    logic                    first_q;
    logic                    grant_acc;
    logic                    grant_drn;
    logic [DATA_WIDTH-1:0]   sum;
    logic                    sum_ovf;
    logic                    acc_overflow;

    psum_sat_adder #(
        .DATA_WIDTH (DATA_WIDTH),
        .SATURATE   (SATURATE)
    ) u_sat_adder (
        .a   (mem_rdata),
        .b   (data_q),
        .sum (sum),
        .ovf (sum_ovf)
    );

    // Round-robin grant in IDLE; acks are combinational so they coincide
    // with the grant edge, and are held low while reset is asserted
    always_comb begin
        grant_acc = 1'b0;
        grant_drn = 1'b0;
        if (reset && state == ST_IDLE) begin
            if (acc_req && (!drn_req || last_grant == REQ_DRN)) begin
                grant_acc = 1'b1;
            end else if (drn_req) begin
                grant_drn = 1'b1;
            end
        end
    end

    // Data-path outputs that depend on the same-cycle SRAM read data
    always_comb begin
        acc_ack      = grant_acc;
        drn_ack      = grant_drn;
        acc_overflow = (state == ST_ACC_WR) && !first_q && sum_ovf;
        mem_wdata    = '0;
        if (state == ST_ACC_WR) begin
            mem_wdata = first_q ? data_q : sum;
        end
        drn_rdata = (state == ST_DRN_RSP) ? mem_rdata : '0;
    end

    // Scheduler FSM; memory strobes are registered alongside the next state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            last_grant <= REQ_DRN;
            addr_q     <= '0;
            data_q     <= '0;
            first_q    <= 1'b0;
            ovf        <= 1'b0;
            mem_ren    <= 1'b0;
            mem_wen    <= 1'b0;
            mem_addr   <= '0;
            drn_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            mem_ren   <= 1'b0;
            mem_wen   <= 1'b0;
            mem_addr  <= '0;
            drn_valid <= 1'b0;
            if (acc_overflow) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (grant_acc) begin
                        last_grant <= REQ_ACC;
                        addr_q     <= acc_addr;
                        data_q     <= acc_data;
                        first_q    <= acc_first;
                        mem_addr   <= acc_addr;
                        busy       <= 1'b1;
                        if (acc_first) begin
                            state   <= ST_ACC_WR;
                            mem_wen <= 1'b1;
                        end else begin
                            state   <= ST_ACC_RD;
                            mem_ren <= 1'b1;
                        end
                    end else if (grant_drn) begin
                        last_grant <= REQ_DRN;
                        addr_q     <= drn_addr;
                        first_q    <= 1'b0;
                        mem_addr   <= drn_addr;
                        mem_ren    <= 1'b1;
                        busy       <= 1'b1;
                        state      <= ST_DRN_RD;
                    end
                end
                ST_ACC_RD: begin
                    state    <= ST_ACC_WR;
                    mem_wen  <= 1'b1;
                    mem_addr <= addr_q;
                end
                ST_DRN_RD: begin
                    state     <= ST_DRN_RSP;
                    drn_valid <= 1'b1;
                end
                ST_DRN_RSP: begin
                    if (CLR_ON_DRN) begin
                        state    <= ST_DRN_CLR;
                        mem_wen  <= 1'b1;
                        mem_addr <= addr_q;
                    end else begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_psum_rmw_scheduler.sv
// Testbench for psum_rmw_scheduler: transaction-level reference model with
// per-cycle output comparison, directed scenarios and a randomized phase.
module tb_psum_rmw_scheduler;

    typedef struct packed {
        logic        ren;
        logic        wen;
        logic        vld;
        logic        busy;
        logic        ovf_set;
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } slot_t;

    logic clk = 1'b0;
    logic reset;
    logic mem_clear;

    // saturating / clearing instance
    logic        acc_req, acc_first, acc_ack, drn_req, drn_ack, drn_valid;
    logic [3:0]  acc_addr, drn_addr, mem_addr;
    logic [15:0] acc_data, drn_rdata, mem_wdata, mem_rdata;
    logic        mem_ren, mem_wen, busy, ovf, clr_ovf;

    // wrapping / non-clearing instance
    logic        b_acc_req, b_acc_first, b_acc_ack, b_drn_req, b_drn_ack, b_drn_valid;
    logic [3:0]  b_acc_addr, b_drn_addr, b_mem_addr;
    logic [15:0] b_acc_data, b_drn_rdata, b_mem_wdata, b_mem_rdata;
    logic        b_mem_ren, b_mem_wen, b_busy, b_ovf, b_clr_ovf;

    logic [15:0] mem_a [16];
    logic [15:0] mem_b [16];

    int checks = 0;
    int errors = 0;

    // reference model state
    slot_t       sched [64];
    logic [15:0] model_mem [16];
    int          cyc = 0;
    int          free_at = 0;
    bit          last_drn = 1'b1;
    bit          ovf_m = 1'b0;

    // observations
    bit          a_acc_ack_s, a_drn_ack_s, b_acc_ack_s, b_drn_ack_s;
    int          a_ack_cyc, a_wen_cyc, a_vld_cyc, acc_ack_cnt, b_vld_cnt;
    logic [15:0] a_wdata_seen, a_rdata_at_wen, a_vld_data, b_wdata_seen, b_vld_data;

    always #5 clk = ~clk;

    psum_rmw_scheduler #(
        .DATA_WIDTH (16), .ADDR_WIDTH (4), .SATURATE (1'b1), .CLR_ON_DRN (1'b1)
    ) dut (
        .clk (clk), .reset (reset),
        .acc_req (acc_req), .acc_first (acc_first), .acc_addr (acc_addr),
        .acc_data (acc_data), .acc_ack (acc_ack),
        .drn_req (drn_req), .drn_addr (drn_addr), .drn_ack (drn_ack),
        .drn_valid (drn_valid), .drn_rdata (drn_rdata),
        .mem_ren (mem_ren), .mem_wen (mem_wen), .mem_addr (mem_addr),
        .mem_wdata (mem_wdata), .mem_rdata (mem_rdata),
        .busy (busy), .ovf (ovf), .clr_ovf (clr_ovf)
    );

    psum_rmw_scheduler #(
        .DATA_WIDTH (16), .ADDR_WIDTH (4), .SATURATE (1'b0), .CLR_ON_DRN (1'b0)
    ) dut_b (
        .clk (clk), .reset (reset),
        .acc_req (b_acc_req), .acc_first (b_acc_first), .acc_addr (b_acc_addr),
        .acc_data (b_acc_data), .acc_ack (b_acc_ack),
        .drn_req (b_drn_req), .drn_addr (b_drn_addr), .drn_ack (b_drn_ack),
        .drn_valid (b_drn_valid), .drn_rdata (b_drn_rdata),
        .mem_ren (b_mem_ren), .mem_wen (b_mem_wen), .mem_addr (b_mem_addr),
        .mem_wdata (b_mem_wdata), .mem_rdata (b_mem_rdata),
        .busy (b_busy), .ovf (b_ovf), .clr_ovf (b_clr_ovf)
    );

    // Single-port SRAMs with one-cycle read latency
    always @(posedge clk) begin
        if (mem_clear) begin
            for (int i = 0; i < 16; i++) begin
                mem_a[i] <= '0;
                mem_b[i] <= '0;
            end
            mem_rdata   <= '0;
            b_mem_rdata <= '0;
        end else begin
            if (mem_wen)   mem_a[mem_addr]   <= mem_wdata;
            if (mem_ren)   mem_rdata         <= mem_a[mem_addr];
            if (b_mem_wen) mem_b[b_mem_addr] <= b_mem_wdata;
            if (b_mem_ren) b_mem_rdata       <= mem_b[b_mem_addr];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [15:0] model_add(input logic [15:0] a, input logic [15:0] b,
                                              output bit o);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        o = (s > 32767) || (s < -32768);
        if (s > 32767) return 16'h7FFF;
        if (s < -32768) return 16'h8000;
        return 16'(s);
    endfunction

    // One clock cycle: sample and compare at negedge, return at posedge+1
    task automatic tick();
        slot_t       e;
        int          c;
        bit          g_acc, g_drn, o;
        logic [15:0] w;
        @(negedge clk);
        c = cyc;
        a_acc_ack_s = acc_ack;
        a_drn_ack_s = drn_ack;
        b_acc_ack_s = b_acc_ack;
        b_drn_ack_s = b_drn_ack;
        if (acc_ack || drn_ack) a_ack_cyc = c;
        if (acc_ack) acc_ack_cnt++;
        if (mem_wen) begin
            a_wen_cyc = c; a_wdata_seen = mem_wdata; a_rdata_at_wen = mem_rdata;
        end
        if (drn_valid) begin
            a_vld_cyc = c; a_vld_data = drn_rdata;
        end
        if (b_mem_wen) b_wdata_seen = b_mem_wdata;
        if (b_drn_valid) begin
            b_vld_data = b_drn_rdata; b_vld_cnt++;
        end
        if (!reset) begin
            chk("reset_ctl", {acc_ack, drn_ack, drn_valid, mem_ren, mem_wen, busy, ovf}, 0);
            chk("reset_addr_wdata", {mem_addr, mem_wdata}, 0);
            chk("reset_rdata", drn_rdata, 0);
            for (int i = 0; i < 64; i++) sched[i] = '0;
            free_at  = c;
            last_drn = 1'b1;
            ovf_m    = 1'b0;
        end else begin
            e = sched[c % 64];
            sched[c % 64] = '0;
            g_acc = 1'b0;
            g_drn = 1'b0;
            if (c >= free_at) begin
                if (acc_req && drn_req) begin
                    g_acc = last_drn;
                    g_drn = !last_drn;
                end else begin
                    g_acc = acc_req;
                    g_drn = drn_req;
                end
            end
            chk("acc_ack", acc_ack, g_acc);
            chk("drn_ack", drn_ack, g_drn);
            chk("mem_ren", mem_ren, e.ren);
            chk("mem_wen", mem_wen, e.wen);
            chk("mem_addr", mem_addr, (e.ren || e.wen) ? e.addr : 4'd0);
            chk("mem_wdata", mem_wdata, e.wen ? e.wdata : 16'd0);
            chk("drn_valid", drn_valid, e.vld);
            chk("drn_rdata", drn_rdata, e.vld ? e.rdata : 16'd0);
            chk("busy", busy, e.busy);
            chk("ovf", ovf, ovf_m);
            chk("ren_wen_excl", mem_ren & mem_wen, 0);
            if (e.wen) model_mem[e.addr] = e.wdata;
            if (e.ovf_set) ovf_m = 1'b1;
            else if (clr_ovf) ovf_m = 1'b0;
            if (g_acc) begin
                last_drn = 1'b0;
                if (acc_first) begin
                    sched[(c+1)%64].wen   = 1'b1;
                    sched[(c+1)%64].addr  = acc_addr;
                    sched[(c+1)%64].wdata = acc_data;
                    sched[(c+1)%64].busy  = 1'b1;
                    free_at = c + 2;
                end else begin
                    w = model_add(model_mem[acc_addr], acc_data, o);
                    sched[(c+1)%64].ren     = 1'b1;
                    sched[(c+1)%64].addr    = acc_addr;
                    sched[(c+1)%64].busy    = 1'b1;
                    sched[(c+2)%64].wen     = 1'b1;
                    sched[(c+2)%64].addr    = acc_addr;
                    sched[(c+2)%64].wdata   = w;
                    sched[(c+2)%64].ovf_set = o;
                    sched[(c+2)%64].busy    = 1'b1;
                    free_at = c + 3;
                end
            end
            if (g_drn) begin
                last_drn = 1'b1;
                sched[(c+1)%64].ren   = 1'b1;
                sched[(c+1)%64].addr  = drn_addr;
                sched[(c+1)%64].busy  = 1'b1;
                sched[(c+2)%64].vld   = 1'b1;
                sched[(c+2)%64].rdata = model_mem[drn_addr];
                sched[(c+2)%64].busy  = 1'b1;
                sched[(c+3)%64].wen   = 1'b1;
                sched[(c+3)%64].addr  = drn_addr;
                sched[(c+3)%64].wdata = 16'd0;
                sched[(c+3)%64].busy  = 1'b1;
                free_at = c + 4;
            end
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic settle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Raise a request, hold it until acked (bounded), then drop it
    task automatic issue(input bit on_b, input bit drn, input bit first,
                         input logic [3:0] addr, input logic [15:0] data);
        bit seen = 1'b0;
        if (on_b) begin
            if (drn) begin b_drn_req = 1'b1; b_drn_addr = addr; end
            else begin b_acc_req = 1'b1; b_acc_first = first; b_acc_addr = addr; b_acc_data = data; end
        end else begin
            if (drn) begin drn_req = 1'b1; drn_addr = addr; end
            else begin acc_req = 1'b1; acc_first = first; acc_addr = addr; acc_data = data; end
        end
        for (int i = 0; i < 30 && !seen; i++) begin
            tick();
            seen = on_b ? (drn ? b_drn_ack_s : b_acc_ack_s) : (drn ? a_drn_ack_s : a_acc_ack_s);
        end
        chk("ack_timeout", seen, 1);
        acc_req = 1'b0; drn_req = 1'b0; b_acc_req = 1'b0; b_drn_req = 1'b0;
    endtask

    initial begin
        int         n;
        logic [3:0] order;
        int         cnt0;
        bit         seen;

        reset = 1'b0; mem_clear = 1'b1; clr_ovf = 1'b0; b_clr_ovf = 1'b0;
        acc_req = 1'b0; acc_first = 1'b0; acc_addr = '0; acc_data = '0;
        drn_req = 1'b0; drn_addr = '0;
        b_acc_req = 1'b0; b_acc_first = 1'b0; b_acc_addr = '0; b_acc_data = '0;
        b_drn_req = 1'b0; b_drn_addr = '0;
        acc_ack_cnt = 0; b_vld_cnt = 0;
        for (int i = 0; i < 16; i++) model_mem[i] = '0;
        for (int i = 0; i < 64; i++) sched[i] = '0;
        @(posedge clk); #1;
        settle(3);
        reset = 1'b1; mem_clear = 1'b0;

        // first write then read-modify-write on the same word
        issue(0, 0, 1, 4'd3, 16'd5);
        settle(2);
        chk("t1_first_latency", a_wen_cyc - a_ack_cyc, 1);
        chk("t1_first_wdata", a_wdata_seen, 16'd5);
        issue(0, 0, 0, 4'd3, 16'd7);
        settle(3);
        chk("t1_rmw_latency", a_wen_cyc - a_ack_cyc, 2);
        chk("t1_rmw_rdata", a_rdata_at_wen, 16'd5);
        chk("t1_rmw_wdata", a_wdata_seen, 16'd12);
        chk("t1_mem3", mem_a[3], 16'd12);

        // drain with clear, then re-drain
        issue(0, 1, 0, 4'd3, 16'd0);
        settle(4);
        chk("t4_valid_latency", a_vld_cyc - a_ack_cyc, 2);
        chk("t4_drain_data", a_vld_data, 16'd12);
        chk("t4_clear_latency", a_wen_cyc - a_vld_cyc, 1);
        chk("t4_clear_wdata", a_wdata_seen, 16'd0);
        chk("t4_mem3_cleared", mem_a[3], 16'd0);
        issue(0, 1, 0, 4'd3, 16'd0);
        settle(4);
        chk("t4_redrain_data", a_vld_data, 16'd0);

        // simultaneous requests alternate
        acc_req = 1'b1; acc_first = 1'b0; acc_addr = 4'd4; acc_data = 16'd1;
        drn_req = 1'b1; drn_addr = 4'd5;
        n = 0; order = '0;
        for (int i = 0; i < 40 && n < 4; i++) begin
            tick();
            if (a_acc_ack_s && n < 4) begin order[n] = 1'b0; n++; end
            if (a_drn_ack_s && n < 4) begin order[n] = 1'b1; n++; end
        end
        acc_req = 1'b0; drn_req = 1'b0;
        chk("t2_grant_count", n, 4);
        chk("t2_grant_order", order, 4'b1010);
        settle(5);

        // saturation and sticky overflow
        issue(0, 0, 1, 4'd6, 16'h7FF0);
        issue(0, 0, 0, 4'd6, 16'h0020);
        settle(4);
        chk("t3_sat_wdata", a_wdata_seen, 16'h7FFF);
        chk("t3_sat_mem", mem_a[6], 16'h7FFF);
        chk("t3_ovf_set", ovf, 1);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        chk("t3_ovf_cleared", ovf, 0);

        // asynchronous reset during the read phase
        issue(0, 0, 0, 4'd7, 16'd3);
        #2 reset = 1'b0;
        #1;
        chk("t5_async_ctl", {acc_ack, drn_ack, drn_valid, mem_ren, mem_wen, busy, ovf}, 0);
        chk("t5_async_data", {mem_addr, mem_wdata}, 0);
        settle(2);
        reset = 1'b1;
        chk("t5_no_write", mem_a[7], 16'd0);
        acc_req = 1'b1; acc_first = 1'b1; acc_addr = 4'd8; acc_data = 16'h0011;
        drn_req = 1'b1; drn_addr = 4'd3;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            seen = a_acc_ack_s || a_drn_ack_s;
        end
        chk("t5_first_tie_acc", {a_acc_ack_s, a_drn_ack_s}, 2'b10);
        acc_req = 1'b0; drn_req = 1'b0;
        settle(4);

        // abandoned accumulate while a drain is in progress
        issue(0, 1, 0, 4'd3, 16'd0);
        cnt0 = acc_ack_cnt;
        acc_req = 1'b1; acc_first = 1'b1; acc_addr = 4'd9; acc_data = 16'h0055;
        tick();
        acc_req = 1'b0;
        settle(5);
        chk("t6_no_ack", acc_ack_cnt - cnt0, 0);
        chk("t6_no_write", mem_a[9], 16'd0);

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            if (acc_req && a_acc_ack_s) acc_req = 1'b0;
            else if (acc_req && $urandom_range(0, 15) == 0) acc_req = 1'b0;
            if (!acc_req && $urandom_range(0, 2) == 0) begin
                acc_req   = 1'b1;
                acc_first = ($urandom_range(0, 3) == 0);
                acc_addr  = 4'($urandom_range(0, 15));
                acc_data  = 16'($urandom);
            end
            if (drn_req && a_drn_ack_s) drn_req = 1'b0;
            else if (drn_req && $urandom_range(0, 15) == 0) drn_req = 1'b0;
            if (!drn_req && $urandom_range(0, 4) == 0) begin
                drn_req  = 1'b1;
                drn_addr = 4'($urandom_range(0, 15));
            end
            clr_ovf = ($urandom_range(0, 9) == 0);
            tick();
        end
        acc_req = 1'b0; drn_req = 1'b0; clr_ovf = 1'b0;
        settle(6);

        // wrapping adder and non-clearing drain
        issue(1, 0, 1, 4'd2, 16'h7FF0);
        settle(2);
        issue(1, 0, 0, 4'd2, 16'h0020);
        settle(4);
        chk("b_wrap_wdata", b_wdata_seen, 16'h8010);
        chk("b_wrap_mem", mem_b[2], 16'h8010);
        chk("b_ovf_set", b_ovf, 1);
        issue(1, 1, 0, 4'd2, 16'd0);
        settle(2);
        chk("b_drain_two_cycle", b_busy, 0);
        settle(2);
        chk("b_drain_data", b_vld_data, 16'h8010);
        chk("b_mem_kept", mem_b[2], 16'h8010);
        issue(1, 1, 0, 4'd2, 16'd0);
        settle(4);
        chk("b_redrain_count", b_vld_cnt, 2);
        chk("b_redrain_data", b_vld_data, 16'h8010);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
